// File: rtl/dsp_pkg.sv
// Shared DSP definitions: streamer FSM encoding, default frame geometry and
// the frame counter width.
package dsp_pkg;

  localparam int DSP_DATA_WIDTH = 16;
  localparam int DSP_N          = 16;
  localparam int FRAME_CNT_W    = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SEND     = 3'd2,
    DONE     = 3'd3,
    WAIT_CLR = 3'd4
  } streamer_state_e;

endpackage

// File: rtl/sample_streamer_if.sv
// Complex sample stream with valid/ready handshake and end-of-frame marker.
interface sample_streamer_if #(
  parameter int DATA_WIDTH = 16
);

  logic signed [DATA_WIDTH-1:0] out_real;
  logic signed [DATA_WIDTH-1:0] out_imag;
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_last;

  modport master (
    output out_real,
    output out_imag,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_real,
    input  out_imag,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/sample_streamer.sv
// Reads one complete frame from an upstream buffer and streams it sample by
// sample over a valid/ready interface, reporting completion, underrun and frame count.
module sample_streamer
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = DSP_DATA_WIDTH,
  parameter int N          = DSP_N
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         buffer_ready,
  input  logic signed [DATA_WIDTH-1:0] real_in [N],
  input  logic signed [DATA_WIDTH-1:0] imag_in [N],
  input  logic                         flush,
  output logic                         read_en,
  output logic [$clog2(N)-1:0]         read_addr,
  output logic                         read_done,
  output logic                         underrun,
  output logic [FRAME_CNT_W-1:0]       frame_count,
  sample_streamer_if.master            out_if
);

  localparam int             AW       = $clog2(N);
  localparam logic [AW-1:0]  LAST_IDX = AW'(N - 1);

  streamer_state_e              state_q, state_d;
  logic [AW-1:0]                idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0] out_real_q, out_real_d;
  logic signed [DATA_WIDTH-1:0] out_imag_q, out_imag_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;
  logic                         read_en_q, read_en_d;
  logic                         read_done_q, read_done_d;
  logic                         underrun_q, underrun_d;
  logic [FRAME_CNT_W-1:0]       frame_count_q, frame_count_d;
  logic                         handshake;

  assign handshake = out_valid_q && out_if.out_ready;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    out_real_d    = out_real_q;
    out_imag_d    = out_imag_q;
    underrun_d    = 1'b0;
    frame_count_d = frame_count_q;

    // flush beats everything; a handshake in the same cycle is simply the last one taken
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (buffer_ready) begin
            state_d = FETCH;
            idx_d   = '0;
          end
        end
        FETCH: begin
          if (!buffer_ready) begin
            state_d    = IDLE;
            idx_d      = '0;
            underrun_d = 1'b1;
          end else begin
            out_real_d = real_in[idx_q];
            out_imag_d = imag_in[idx_q];
            state_d    = SEND;
          end
        end
        SEND: begin
          if (!buffer_ready) begin
            state_d    = IDLE;
            idx_d      = '0;
            underrun_d = 1'b1;
          end else if (handshake) begin
            if (idx_q == LAST_IDX) begin
              state_d       = DONE;
              frame_count_d = frame_count_q + 1'b1;
            end else begin
              state_d = FETCH;
              idx_d   = idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_d = WAIT_CLR;
        end
        WAIT_CLR: begin
          // the finished frame must be released before another one is accepted
          if (!buffer_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end

    // strobes are derived from the next state so they register alongside it
    read_en_d   = (state_d == FETCH);
    out_valid_d = (state_d == SEND);
    read_done_d = (state_d == DONE);
    out_last_d  = (state_d == SEND) && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      out_real_q    <= '0;
      out_imag_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      read_en_q     <= 1'b0;
      read_done_q   <= 1'b0;
      underrun_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      out_real_q    <= out_real_d;
      out_imag_q    <= out_imag_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      read_en_q     <= read_en_d;
      read_done_q   <= read_done_d;
      underrun_q    <= underrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign read_en          = read_en_q;
  assign read_addr        = idx_q;
  assign read_done        = read_done_q;
  assign underrun         = underrun_q;
  assign frame_count      = frame_count_q;
  assign out_if.out_real  = out_real_q;
  assign out_if.out_imag  = out_imag_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_last  = out_last_q;

endmodule

// File: tb/tb_sample_streamer.sv
// Directed bench for sample_streamer: nominal frame, backpressure, underrun,
// flush, mid-frame reset and frame counter wrap.
module tb_sample_streamer;

  localparam int DW = 16;
  localparam int NS = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 buffer_ready;
  logic                 flush;
  logic signed [DW-1:0] real_in [NS];
  logic signed [DW-1:0] imag_in [NS];
  logic                 read_en;
  logic [3:0]           read_addr;
  logic                 read_done;
  logic                 underrun;
  logic [7:0]           frame_count;

  int checks = 0;
  int errors = 0;
  int beats;
  int done_cyc;

  sample_streamer_if #(.DATA_WIDTH(DW)) sif ();

  sample_streamer #(.DATA_WIDTH(DW), .N(NS)) dut (
    .clk          (clk),
    .reset        (reset),
    .buffer_ready (buffer_ready),
    .real_in      (real_in),
    .imag_in      (imag_in),
    .flush        (flush),
    .read_en      (read_en),
    .read_addr    (read_addr),
    .read_done    (read_done),
    .underrun     (underrun),
    .frame_count  (frame_count),
    .out_if       (sif)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic load_ramp();
    for (int k = 0; k < NS; k++) begin
      real_in[k] = 16'(k);
      imag_in[k] = 16'(-k);
    end
  endtask

  task automatic load_extreme();
    for (int k = 0; k < NS; k++) begin
      real_in[k] = (k % 2 == 1) ? 16'h7FFF - 16'(k) : 16'h8000 + 16'(k);
      imag_in[k] = ~real_in[k];
    end
  endtask

  // From DONE, WAIT_CLR or IDLE: release the buffer, then present a new frame.
  task automatic start_frame();
    buffer_ready = 1'b0;
    tick();
    tick();
    buffer_ready = 1'b1;
    tick();
  endtask

  // Called in the FETCH cycle of index 0; stops at the cycle read_done is high.
  task automatic collect(input int stall_at, input int stall_len,
                         output int nbeats, output int dcyc);
    int  stalls;
    int  bi;
    bit  done;
    stalls = 0;
    done   = 1'b0;
    nbeats = 0;
    dcyc   = -1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (read_done) begin
        done = 1'b1;
        dcyc = cyc;
      end else begin
        if (sif.out_valid) begin
          bi = (nbeats < NS) ? nbeats : NS - 1;
          check("beat_real", sif.out_real, real_in[bi]);
          check("beat_imag", sif.out_imag, imag_in[bi]);
          check("beat_last", sif.out_last, (nbeats == NS - 1) ? 1 : 0);
          if (nbeats == stall_at && stalls < stall_len) begin
            sif.out_ready = 1'b0;
            stalls++;
          end else begin
            sif.out_ready = 1'b1;
            nbeats++;
          end
        end else begin
          check("last_without_valid", sif.out_last, 0);
          sif.out_ready = 1'b1;
        end
        tick();
      end
    end
    if (!done) check("frame_timeout", 0, 1);
  endtask

  initial begin
    reset         = 1'b1;
    buffer_ready  = 1'b0;
    flush         = 1'b0;
    sif.out_ready = 1'b1;
    load_ramp();
    tick();
    tick();

    check("rst_read_en", read_en, 0);
    check("rst_read_done", read_done, 0);
    check("rst_out_valid", sif.out_valid, 0);
    check("rst_out_last", sif.out_last, 0);
    check("rst_underrun", underrun, 0);
    check("rst_out_real", sif.out_real, 0);
    check("rst_out_imag", sif.out_imag, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_read_addr", read_addr, 0);

    reset = 1'b0;
    tick();
    check("idle_no_read", read_en, 0);

    // nominal frame
    buffer_ready = 1'b1;
    tick();
    check("nom_fetch_en", read_en, 1);
    check("nom_fetch_addr", read_addr, 0);
    check("nom_fetch_valid", sif.out_valid, 0);
    collect(-1, 0, beats, done_cyc);
    check("nom_beats", beats, 16);
    check("nom_latency", done_cyc, 32);
    check("nom_read_done", read_done, 1);
    check("nom_frame_count", frame_count, 1);
    tick();
    check("nom_done_pulse", read_done, 0);
    check("nom_frame_count_hold", frame_count, 1);
    repeat (4) begin
      tick();
      check("no_restart_read_en", read_en, 0);
      check("no_restart_valid", sif.out_valid, 0);
    end

    // backpressure on sample 3
    start_frame();
    check("bp_fetch_addr", read_addr, 0);
    collect(3, 5, beats, done_cyc);
    check("bp_beats", beats, 16);
    check("bp_latency", done_cyc, 37);
    check("bp_frame_count", frame_count, 2);

    // underrun while sending sample 7
    start_frame();
    repeat (15) tick();
    check("ur_pre_valid", sif.out_valid, 1);
    check("ur_pre_real", sif.out_real, 7);
    check("ur_pre_addr", read_addr, 7);
    buffer_ready = 1'b0;
    tick();
    check("ur_pulse", underrun, 1);
    check("ur_valid_drop", sif.out_valid, 0);
    check("ur_no_done", read_done, 0);
    check("ur_frame_count", frame_count, 2);
    tick();
    check("ur_pulse_end", underrun, 0);
    check("ur_no_done2", read_done, 0);
    check("ur_valid_low", sif.out_valid, 0);
    start_frame();
    check("ur_restart_addr", read_addr, 0);
    check("ur_restart_en", read_en, 1);
    collect(-1, 0, beats, done_cyc);
    check("ur_next_beats", beats, 16);
    check("ur_next_frame_count", frame_count, 3);

    // flush at sample 10, together with a handshake and a dropped buffer_ready
    start_frame();
    repeat (21) tick();
    check("fl_pre_real", sif.out_real, 10);
    check("fl_pre_valid", sif.out_valid, 1);
    flush        = 1'b1;
    buffer_ready = 1'b0;
    tick();
    flush = 1'b0;
    check("fl_valid", sif.out_valid, 0);
    check("fl_no_underrun", underrun, 0);
    check("fl_no_done", read_done, 0);
    check("fl_read_en", read_en, 0);
    check("fl_last", sif.out_last, 0);
    tick();
    check("fl_no_underrun2", underrun, 0);
    check("fl_no_done2", read_done, 0);
    check("fl_frame_count", frame_count, 3);

    // asynchronous reset at sample 10
    start_frame();
    repeat (21) tick();
    check("rs_pre_real", sif.out_real, 10);
    reset        = 1'b1;
    buffer_ready = 1'b0;
    #1;
    check("rs_valid", sif.out_valid, 0);
    check("rs_real", sif.out_real, 0);
    check("rs_imag", sif.out_imag, 0);
    check("rs_read_en", read_en, 0);
    check("rs_last", sif.out_last, 0);
    check("rs_addr", read_addr, 0);
    check("rs_frame_count", frame_count, 0);
    tick();
    reset = 1'b0;
    repeat (2) begin
      tick();
      check("rs_post_done", read_done, 0);
      check("rs_post_underrun", underrun, 0);
      check("rs_post_read_en", read_en, 0);
    end

    // 256 frames of full-scale data: counter wraps back to zero
    load_extreme();
    for (int f = 0; f < 256; f++) begin
      start_frame();
      collect(-1, 0, beats, done_cyc);
      check("wrap_beats", beats, 16);
      check("wrap_frame_count", frame_count, (f + 1) % 256);
    end
    check("wrap_final", frame_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
